dram_serializer: RTL and testbench
==================================

// Module: dram_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out serializer for the DRAM write-data path.
//  Accepts DATA_W-bit words over a valid/ready handshake and emits them SER_W bits per beat, LSB- or MSB-first.
//  A one-word holding buffer lets the next word load without a bubble, and shift_en stalls output to match pin timing.
//  Sits between the write-data FIFO and the DQ output stage.
// PARAMETERS
//  DATA_W     16  parallel word width; must be an integer multiple of SER_W
//  SER_W       1  bits emitted per beat (1,2,4,8)
//  MSB_FIRST   0  0: word bits [SER_W-1:0] go first; 1: bits [DATA_W-1:DATA_W-SER_W] go first
// PORTS
//  clk        in   1        clock
//  rst_b      in   1        reset, asynchronous, active-low
//  flush      in   1        synchronous clear of buffer, shifter and counter
//  in_valid   in   1        input word valid
//  in_ready   out  1        buffer can accept a word
//  in_data    in   DATA_W   parallel word
//  shift_en   in   1        advance one beat this cycle; 0 = hold current beat
//  out_valid  out  1        out_data carries a live beat
//  out_data   out  SER_W    current beat
//  out_last   out  1        current beat is the final beat of its word
// BEHAVIOUR
//  Definitions:
//  - BEATS = DATA_W/SER_W (plus 1 with parity); beat_cnt is $clog2(BEATS) bits wide.
//  - Illegal DATA_W%SER_W != 0 is a fatal elaboration error.
//  Reset values:
//  - in_ready=1, out_valid=0, out_data=0, out_last=0; hold empty; state IDLE; beat_cnt=0.
//  - Reset is honoured mid-word; the partial word is discarded.
//  Input:
//  - Accept when in_valid&&in_ready; word goes to hold register. in_ready = !hold_full (registered).
//  State machine:
//  - IDLE: if hold_full, load shifter from hold, clear hold, beat_cnt=0, go SHIFT.
//  - SHIFT: out_valid=1. On shift_en, shifter moves SER_W bits toward the output end (zero fill) and beat_cnt++.
//  - SHIFT, last beat with shift_en: if hold_full, reload shifter and stay in SHIFT (no gap); else go IDLE.
//  - Accept and hold-drain in the same cycle are allowed; hold stays full with the new word.
//  Output:
//  - out_last = out_valid && (beat_cnt==BEATS-1). out_data=0 whenever out_valid=0.
//  - Latency: word accepted at edge N gives its first beat at edge N+2 if the shifter is idle.
//  - Sustained rate is one word per BEATS shift_en cycles.
//  Flush:
//  - Beats IDLE, hold empty, beat_cnt=0 next edge; takes priority over a same-cycle accept (word dropped).
//  - shift_en in IDLE has no effect.
// CONFIGURATION
//  DRAM_SER_PARITY_EN defined:
//  - Hold/shifter also store p=^word; after the last data beat one extra beat {SER_W{p}} is emitted.
//  - out_last is asserted on that parity beat.
//  DRAM_SER_PARITY_EN undefined: no parity logic; exactly DATA_W/SER_W beats per word.
// TESTING (DATA_W=16, SER_W=1 unless stated)
//  - Reset during SHIFT at beat 5 -> out_valid=0, in_ready=1 immediately; next word starts at beat 0.
//  - MSB_FIRST=0, word 0xA5C3, shift_en=1 -> beats 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; out_last on 16th; first beat 2 cycles after accept.
//  - MSB_FIRST=1, SER_W=4, word 0x1234 -> out_data 1,2,3,4; out_last with 4; no bubble if 0xBEEF already held -> B,E,E,F follow.
//  - shift_en low for 3 cycles at beat 7 -> out_data/beat_cnt frozen; in_ready=0 while hold full; resumes at beat 8.
//  - flush asserted with in_valid at beat 3 -> next edge out_valid=0, accepted word discarded, hold empty.
//  - DRAM_SER_PARITY_EN, word 0x0007 -> 16 data beats then parity beat 1 with out_last; word 0x0003 -> parity 0.

Source files
------------

// File: rtl/dram_serializer.sv
// dram_serializer: parallel-in/serial-out DQ write-data serializer with a one-word hold buffer.
// Define DRAM_SER_PARITY_EN to append a parity beat {SER_W{^word}} after each word.
module dram_serializer #(
  parameter int DATA_W    = 16,
  parameter int SER_W     = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              shift_en,
  output logic              out_valid,
  output logic [SER_W-1:0]  out_data,
  output logic              out_last
);

  localparam int DATA_BEATS = DATA_W / SER_W;
`ifdef DRAM_SER_PARITY_EN
  localparam int BEATS = DATA_BEATS + 1;
`else
  localparam int BEATS = DATA_BEATS;
`endif
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  if ((DATA_W % SER_W) != 0) begin : g_width_check
    $fatal(1, "dram_serializer: DATA_W must be an integer multiple of SER_W");
  end

  logic [0:0]        state;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] shifter;
  logic [DATA_W-1:0] shifted;
  logic [CNT_W-1:0]  beat_cnt;
  logic [SER_W-1:0]  data_beat;
  logic              accept;
  logic              advance;
  logic              last_beat;
  logic              reload;
`ifdef DRAM_SER_PARITY_EN
  logic              hold_par;
  logic              sh_par;
`endif

  assign accept    = in_valid && in_ready;
  assign advance   = (state == SHIFT) && shift_en;
  assign last_beat = (state == SHIFT) && (beat_cnt == LAST_CNT);
  // The hold word moves into the shifter either from idle or straight after the last beat.
  assign reload    = hold_full && ((state == IDLE) || (advance && last_beat));

  assign shifted   = MSB_FIRST ? (shifter << SER_W) : (shifter >> SER_W);
  assign data_beat = MSB_FIRST ? shifter[DATA_W-1 -: SER_W] : shifter[SER_W-1:0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      hold_data <= '0;
      shifter   <= '0;
      beat_cnt  <= '0;
`ifdef DRAM_SER_PARITY_EN
      hold_par  <= 1'b0;
      sh_par    <= 1'b0;
`endif
    end else if (flush) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      shifter   <= '0;
      beat_cnt  <= '0;
    end else begin
      // A same-cycle accept overwrites the word being drained, so hold stays full.
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
`ifdef DRAM_SER_PARITY_EN
        hold_par  <= ^in_data;
`endif
      end else if (reload) begin
        hold_full <= 1'b0;
      end

      if (reload) begin
        state    <= SHIFT;
        shifter  <= hold_data;
        beat_cnt <= '0;
`ifdef DRAM_SER_PARITY_EN
        sh_par   <= hold_par;
`endif
      end else if (advance) begin
        if (last_beat) begin
          state    <= IDLE;
          shifter  <= '0;
          beat_cnt <= '0;
        end else begin
          shifter  <= shifted;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  assign in_ready  = !hold_full;
  assign out_valid = (state == SHIFT);
  assign out_last  = out_valid && (beat_cnt == LAST_CNT);

`ifdef DRAM_SER_PARITY_EN
  assign out_data = !out_valid ? '0 :
                    (beat_cnt == CNT_W'(DATA_BEATS)) ? {SER_W{sh_par}} : data_beat;
`else
  assign out_data = out_valid ? data_beat : '0;
`endif

endmodule

// File: tb/tb_dram_serializer.sv
// Bench for dram_serializer: directed 1-bit LSB-first sequences, a vector table on a
// 4-bit MSB-first instance, and random traffic scored against a beat-queue model.
`timescale 1ns/1ps
module tb_dram_serializer;

`ifdef DRAM_SER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BEATS1 = 16 + PAR;
  localparam int BEATS4 = 4 + PAR;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        flush = 1'b0, in_valid = 1'b0, shift_en = 1'b0;
  logic        in_ready, out_valid, out_last;
  logic [15:0] in_data = '0;
  logic [0:0]  out_data;
  logic        flush4 = 1'b0, in_valid4 = 1'b0, shift_en4 = 1'b0;
  logic        in_ready4, out_valid4, out_last4;
  logic [15:0] in_data4 = '0;
  logic [3:0]  out_data4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dram_serializer #(.DATA_W(16), .SER_W(1), .MSB_FIRST(1'b0)) u_dut (
    .clk(clk), .rst_b(rst_b), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .shift_en(shift_en), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last)
  );

  dram_serializer #(.DATA_W(16), .SER_W(4), .MSB_FIRST(1'b1)) u_dut4 (
    .clk(clk), .rst_b(rst_b), .flush(flush4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .shift_en(shift_en4), .out_valid(out_valid4), .out_data(out_data4),
    .out_last(out_last4)
  );

  typedef struct packed { logic data; logic last; } beat_t;
  typedef struct packed { logic [3:0] data; logic last; } beat4_t;
  typedef struct packed { logic [15:0] word; logic [3:0] n0, n1, n2, n3; logic par; } vec_t;

  beat_t exp_q[$];
  bit    exp_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic se, input logic fl);
    in_valid = v;
    in_data  = d;
    shift_en = se;
    flush    = fl;
  endtask

  // Beat i of a word on the 1-bit LSB-first instance; the beat after the data is parity.
  function automatic logic expBeat1(input logic [15:0] w, input int i);
    if (i < 16) return logic'((w >> i) & 16'd1);
    return logic'($countones(w) % 2);
  endfunction

  function automatic int wordsQueued();
    int n = 0;
    foreach (exp_q[k]) if (exp_q[k].last) n++;
    return n;
  endfunction

  task automatic pushWord(input logic [15:0] w);
    beat_t b;
    for (int i = 0; i < BEATS1; i++) begin
      b.data = expBeat1(w, i);
      b.last = (i == BEATS1 - 1);
      exp_q.push_back(b);
    end
  endtask

  // Offers one word to the idle 1-bit instance and returns at the negedge showing beat 0.
  task automatic startWord1(input logic [15:0] w);
    @(negedge clk);
    applyStimulus(1'b1, w, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("lat_hold_valid", 32'(out_valid), 32'd0);
    checkOutput("lat_hold_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("lat_first_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic waitIdle1(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = !out_valid && in_ready;
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  task automatic randStep(input bit allow_in);
    logic v_s, r_s;
    bit   fl, acc;
    @(negedge clk);
    v_s = out_valid;
    r_s = in_ready;
    checkOutput("rand_valid", 32'(v_s), 32'(exp_valid));
    if (v_s && exp_q.size() > 0) begin
      checkOutput("rand_data", 32'(out_data), 32'(exp_q[0].data));
      checkOutput("rand_last", 32'(out_last), 32'(exp_q[0].last));
    end else if (!v_s) begin
      checkOutput("rand_idle_data", 32'(out_data), 32'd0);
    end
    checkOutput("rand_ready", 32'(r_s),
                32'(!(exp_valid ? (wordsQueued() >= 2) : (wordsQueued() >= 1))));
    fl = allow_in && ($urandom_range(0, 47) == 0);
    applyStimulus(allow_in && ($urandom_range(0, 1) == 1), 16'($urandom),
                  allow_in ? ($urandom_range(0, 3) != 0) : 1'b1, fl);
    acc = in_valid && r_s && !fl;
    if (fl) begin
      exp_q.delete();
      exp_valid = 1'b0;
    end else begin
      if (exp_valid && shift_en && exp_q.size() > 0) void'(exp_q.pop_front());
      exp_valid = (exp_q.size() > 0);
      if (acc) pushWord(in_data);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int     a5c3 [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    vec_t   tbl [4];
    beat4_t exp4[$];
    beat4_t e4;
    int     wi, bi, n;
    bit     acc4, started;
    logic [15:0] w1;

    tbl[0] = '{word: 16'h1234, n0: 4'h1, n1: 4'h2, n2: 4'h3, n3: 4'h4, par: 1'b1};
    tbl[1] = '{word: 16'hBEEF, n0: 4'hB, n1: 4'hE, n2: 4'hE, n3: 4'hF, par: 1'b1};
    tbl[2] = '{word: 16'h0F0F, n0: 4'h0, n1: 4'hF, n2: 4'h0, n3: 4'hF, par: 1'b0};
    tbl[3] = '{word: 16'h8001, n0: 4'h8, n1: 4'h0, n2: 4'h0, n3: 4'h1, par: 1'b0};

    // Reset values on both instances.
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst4_ready", 32'(in_ready4), 32'd1);
    checkOutput("rst4_valid", 32'(out_valid4), 32'd0);
    rst_b = 1'b1;

    // 0xA5C3, LSB first, continuous shift_en.
    startWord1(16'hA5C3);
    for (int i = 0; i < BEATS1; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("a5c3_valid", 32'(out_valid), 32'd1);
      checkOutput("a5c3_data", 32'(out_data), (i < 16) ? 32'(a5c3[i]) : 32'd0);
      checkOutput("a5c3_last", 32'(out_last), 32'(i == BEATS1 - 1));
    end
    @(negedge clk);
    checkOutput("a5c3_done", 32'(out_valid), 32'd0);

    // Stall at beat 7 with a second word waiting in hold.
    w1 = 16'h5C80;
    @(negedge clk);
    applyStimulus(1'b1, w1, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stall_b0", 32'(out_data), 32'(expBeat1(w1, 0)));
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      applyStimulus(1'b0, 16'h0, (k != 7), 1'b0);
      checkOutput("stall_beat", 32'(out_data), 32'(expBeat1(w1, k)));
    end
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checkOutput("stall_frozen", 32'(out_data), 32'(expBeat1(w1, 7)));
      checkOutput("stall_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_last", 32'(out_last), 32'd0);
      if (s == 2) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    end
    @(negedge clk);
    checkOutput("stall_resume", 32'(out_data), 32'(expBeat1(w1, 8)));
    waitIdle1("stall_drain");

    // Flush at beat 3 together with a new word.
    startWord1(16'h6E21);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_ready", 32'(in_ready), 32'd1);
    checkOutput("flush_data", 32'(out_data), 32'd0);
    @(negedge clk);
    checkOutput("flush_dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset at beat 5, then a fresh word.
    startWord1(16'h3C5A);
    repeat (5) @(negedge clk);
    rst_b = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_ready", 32'(in_ready), 32'd1);
    checkOutput("arst_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    startWord1(16'h8001);
    checkOutput("arst_b0", 32'(out_data), 32'd1);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) n++;
      if (out_valid && out_last) break;
      @(negedge clk);
    end
    checkOutput("arst_beats", 32'(n), 32'(BEATS1));
    @(negedge clk);
    checkOutput("arst_done", 32'(out_valid), 32'd0);

    // Table on the 4-bit MSB-first instance, words streamed back to back.
    foreach (tbl[t]) begin
      e4.last = 1'b0;
      e4.data = tbl[t].n0; exp4.push_back(e4);
      e4.data = tbl[t].n1; exp4.push_back(e4);
      e4.data = tbl[t].n2; exp4.push_back(e4);
      e4.data = tbl[t].n3; e4.last = (PAR == 0); exp4.push_back(e4);
      if (PAR != 0) begin
        e4.data = {4{tbl[t].par}}; e4.last = 1'b1; exp4.push_back(e4);
      end
    end
    wi = 0; bi = 0; acc4 = 1'b0; started = 1'b0;
    shift_en4 = 1'b1;
    for (int c = 0; c < 300 && bi < exp4.size(); c++) begin
      @(negedge clk);
      if (out_valid4) begin
        checkOutput("ser4_data", 32'(out_data4), 32'(exp4[bi].data));
        checkOutput("ser4_last", 32'(out_last4), 32'(exp4[bi].last));
        bi++;
        started = 1'b1;
      end else if (started) begin
        checkOutput("ser4_bubble", 32'(out_valid4), 32'd1);
      end
      if (acc4) wi++;
      in_valid4 = (wi < 4);
      in_data4  = (wi < 4) ? tbl[wi].word : 16'h0;
      acc4      = in_valid4 && in_ready4;
    end
    in_valid4 = 1'b0;
    checkOutput("ser4_all_beats", 32'(bi), 32'(4 * BEATS4));

    // Randomized traffic against the beat-queue model, then drain.
    exp_q.delete();
    exp_valid = 1'b0;
    for (int s = 0; s < 1500; s++) randStep(1'b1);
    for (int s = 0; s < 60; s++) randStep(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
